sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ACC_CYC, default 2, meaning the number of clk cycles the SRAM strobes are held per access (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock (50 MHz board clock); all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have ports a_req, input, 1 / a_we, input, 1 / a_addr, input, 19 / a_wdata, input, 8: port A (Z88 core) byte request.
REQ-005 SHALL have ports a_ack, output, 1 / a_rdata, output, 8: port A completion and read data.
REQ-006 SHALL have ports b_req, input, 1 / b_we, input, 1 / b_addr, input, 19 / b_wdata, input, 8: port B (image loader/debug) byte request.
REQ-007 SHALL have ports b_ack, output, 1 / b_rdata, output, 8: port B completion and read data.
REQ-008 SHALL have ports sram_addr, output, 18 / sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, output, 1 each: 256Kx16 SRAM controls.
REQ-009 SHALL have ports sram_dq_o, output, 16 / sram_dq_oe, output, 1 / sram_dq_i, input, 16: split data bus; the top level builds the tristate.

Function
REQ-010 SHALL implement states IDLE, ACCESS and ACK.
REQ-011 In IDLE with any request pending, SHALL grant exactly one port, register its we/addr/wdata, load the counter with ACC_CYC-1 and enter ACCESS on the next edge.
REQ-012 SHALL arbitrate round-robin: when both requests are pending, grant the port not granted last; a single pending request is granted immediately.
REQ-013 The last-grant pointer SHALL reset to B, so port A wins the first contention.
REQ-014 In ACCESS: sram_ce_n=0; sram_addr=addr[18:1]; byte lane ub_n=~addr[0], lb_n=addr[0].
REQ-015 In ACCESS for a read: oe_n=0, we_n=1, dq_oe=0.
REQ-016 In ACCESS for a write: we_n=0, oe_n=1, dq_oe=1, sram_dq_o={wdata,wdata}.
REQ-017 ACCESS SHALL last exactly ACC_CYC cycles, decrementing the counter each cycle.
REQ-018 On the last ACCESS cycle, SHALL register the selected byte of sram_dq_i (addr[0]=1 -> [15:8], else [7:0]) into the granted port's rdata, and enter ACK.
REQ-019 In ACK: assert the granted port's ack for exactly one cycle; all SRAM strobes inactive (ce_n=oe_n=we_n=ub_n=lb_n=1, dq_oe=0); return to IDLE.
REQ-020 Latency SHALL be ACC_CYC+1 cycles from the IDLE edge sampling req to the ack cycle; peak rate is one access per ACC_CYC+2 cycles.
REQ-021 Requesters SHALL hold req, we, addr and wdata stable until ack; a req seen during ACK SHALL NOT be granted before the following IDLE cycle.
REQ-022 A request dropped before ack is a protocol violation: the access in flight SHALL still complete and ack.
REQ-023 rdata SHALL hold its value until the next read completion on that port; writes SHALL NOT alter rdata.
REQ-024 a_ack and b_ack SHALL never be asserted in the same cycle.
REQ-025 sram_dq_oe SHALL never be 1 while sram_oe_n=0.
REQ-026 Address bit 18 wraps: 19'h7FFFF maps to sram_addr 18'h3FFFF, upper lane.

Reset
REQ-027 While reset_n=0 at a clock edge: state=IDLE, counter=0, pointer=B, acks=0, rdata=8'h00, sram_addr=0, all SRAM strobes=1, dq_oe=0, sram_dq_o=0.
REQ-028 Reset asserted mid-ACCESS SHALL abort the access with no ack; strobes are inactive from the next edge.

Verification
REQ-029 ACC_CYC=2, A reads 19'h00001 with sram_dq_i=16'hAB12 -> ce_n/oe_n/ub_n low for 2 cycles, lb_n high, a_ack on cycle 3, a_rdata=8'hAB.
REQ-030 B writes 8'h5A to 19'h00010 -> sram_addr=18'h00008, we_n low for 2 cycles, lb_n low, ub_n high, sram_dq_o=16'h5A5A, dq_oe high only during ACCESS, b_ack on cycle 3.
REQ-031 a_req and b_req asserted together from reset, held after each ack -> grants A, B, A, B; each ack 4 cycles apart.
REQ-032 Only a_req held continuously -> back-to-back A accesses every 4 cycles; b_ack stays 0.
REQ-033 reset_n driven low on the 2nd ACCESS cycle of a write -> we_n=1 on the next edge, no ack; the next grant after release goes to A.
REQ-034 ACC_CYC=1, a read of 19'h7FFFF -> sram_addr=18'h3FFFF, ub_n low, ack 2 cycles after req sampled.

Source files
------------

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-port byte arbiter in front of a 256Kx16 asynchronous SRAM. Port A serves
// the Z88 core, port B the image loader / debug path. Each port issues byte
// requests on a 19-bit byte address. Bit 0 selects the byte lane and bits
// 18:1 select the 16-bit SRAM word.
//
// Every access is a fixed sequence of three phases:
//   IDLE   : sample requests, grant one port round-robin, latch its command
//   ACCESS : drive the SRAM strobes for ACC_CYC cycles
//   ACK    : pulse the granted port's ack for one cycle, strobes inactive
//
// Parameters
//   ACC_CYC     : cycles the SRAM strobes are held per access (1..15)
//
// Ports
//   clk         : system clock, rising edge
//   reset_n     : synchronous, active-low reset
//   a_*         : port A request (req/we/addr/wdata), completion (ack/rdata)
//   b_*         : port B request (req/we/addr/wdata), completion (ack/rdata)
//   sram_addr   : SRAM word address
//   sram_*_n    : SRAM chip/output/write enables and byte-lane strobes
//   sram_dq_o   : write data; the byte is replicated on both lanes
//   sram_dq_oe  : data bus output enable; the tristate is built at top level
//   sram_dq_i   : read data from the SRAM
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ACC_CYC = 2
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [18:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_ack,
    output logic [7:0]  a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [18:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic [7:0]  b_rdata,

    output logic [17:0] sram_addr,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    // The counter is loaded with ACC_CYC-1 so that ACCESS ends on the cycle
    // in which the counter reads zero.
    localparam logic [3:0] CNT_LOAD = 4'(ACC_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_b_q, last_b_d;    // 1: port B was granted most recently
    logic        gnt_b_q, gnt_b_d;      // port owning the access in flight
    logic        we_q, we_d;
    logic [18:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  a_rdata_q, a_rdata_d;
    logic [7:0]  b_rdata_q, b_rdata_d;

    logic        grant_b;
    logic [7:0]  rd_byte;

    // Under contention the port not served last wins. A lone request wins
    // outright.
    assign grant_b = (a_req && b_req) ? ~last_b_q : b_req;

    // Odd byte addresses live in the upper lane.
    assign rd_byte = addr_q[0] ? sram_dq_i[15:8] : sram_dq_i[7:0];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            last_b_q  <= 1'b1;
            gnt_b_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 19'd0;
            wdata_q   <= 8'h00;
            a_rdata_q <= 8'h00;
            b_rdata_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_b_q  <= last_b_d;
            gnt_b_q   <= gnt_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_b_d  = last_b_q;
        gnt_b_d   = gnt_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    state_d  = ACCESS;
                    cnt_d    = CNT_LOAD;
                    gnt_b_d  = grant_b;
                    last_b_d = grant_b;
                    we_d     = grant_b ? b_we    : a_we;
                    addr_d   = grant_b ? b_addr  : a_addr;
                    wdata_d  = grant_b ? b_wdata : a_wdata;
                end
            end

            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACK;
                    // Read data is captured while oe_n is still asserted.
                    // Writes leave both rdata registers untouched.
                    if (!we_q) begin
                        if (gnt_b_q) begin
                            b_rdata_d = rd_byte;
                        end else begin
                            a_rdata_d = rd_byte;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ACK: begin
                // Requests are not looked at here. A requester that keeps
                // req high is granted in the following IDLE cycle.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_ub_n  = 1'b1;
        sram_lb_n  = 1'b1;
        sram_dq_oe = 1'b0;
        a_ack      = 1'b0;
        b_ack      = 1'b0;

        case (state_q)
            ACCESS: begin
                sram_ce_n = 1'b0;
                sram_ub_n = ~addr_q[0];
                sram_lb_n = addr_q[0];
                if (we_q) begin
                    sram_we_n  = 1'b0;
                    sram_dq_oe = 1'b1;
                end else begin
                    // dq_oe stays low, so the bus is never driven while the
                    // SRAM drives it.
                    sram_oe_n = 1'b0;
                end
            end

            ACK: begin
                a_ack = ~gnt_b_q;
                b_ack = gnt_b_q;
            end

            default: begin
            end
        endcase
    end

    assign sram_addr = addr_q[18:1];
    assign sram_dq_o = {wdata_q, wdata_q};
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;

endmodule
